mem_bus_arbiter: RTL and testbench

Shared-memory arbiter for the dual-core CPU. It is the responder side of the `grant` handshake used by each core's multicycle controller. It accepts byte read/write requests from core 0 and core 1 and grants the single memory port to one core at a time. It drives the shared byte-wide memory and keeps a core's consecutive requests (e.g. a 4-byte instruction fetch) together up to a burst limit, then hands over round-robin.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/mem_bus_arbiter_rr_pick2.sv | 12 +
 rtl/mem_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Definitions shared by the dual-core CPU blocks.
// Covers the bus widths and the memory arbiter state encoding.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker.
// pick=1 selects core 1; on a tie the core that did not own the bus last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick
);

    assign pick = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared byte-memory arbiter for the two cores.
// A core keeps the port across back-to-back requests, up to MAX_BURST grants while the other core waits.
module mem_bus_arbiter #(
    parameter int ADDR_W    = cpu_pkg::ADDR_W,
    parameter int DATA_W    = cpu_pkg::DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              rd1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              grant0,
    output logic              grant1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    cpu_pkg::arb_state_t state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                req0, req1, pick;

    assign req0   = rd0 | wr0;
    assign req1   = rd1 | wr1;
    assign grant0 = (state_q == cpu_pkg::ARB_OWN0) & req0;
    assign grant1 = (state_q == cpu_pkg::ARB_OWN1) & req1;
    assign rdata  = mem_rdata;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .pick (pick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            cpu_pkg::ARB_IDLE: begin
                if (req0 | req1) begin
                    state_d = pick ? cpu_pkg::ARB_OWN1 : cpu_pkg::ARB_OWN0;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            cpu_pkg::ARB_OWN0: begin
                // Dropping the request releases the bus at this edge, even for one cycle.
                if (!req0) begin
                    cnt_d   = '0;
                    state_d = req1 ? cpu_pkg::ARB_OWN1 : cpu_pkg::ARB_IDLE;
                    if (req1) last_d = 1'b1;
                end else if (cnt_q == CNT_MAX && req1) begin
                    state_d = cpu_pkg::ARB_OWN1;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            cpu_pkg::ARB_OWN1: begin
                if (!req1) begin
                    cnt_d   = '0;
                    state_d = req0 ? cpu_pkg::ARB_OWN0 : cpu_pkg::ARB_IDLE;
                    if (req0) last_d = 1'b0;
                end else if (cnt_q == CNT_MAX && req0) begin
                    state_d = cpu_pkg::ARB_OWN0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = cpu_pkg::ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // last resets to core 1 so core 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= cpu_pkg::ARB_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (grant0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = wr0;
            mem_re    = rd0 & ~wr0;
        end else if (grant1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = wr1;
            mem_re    = rd1 & ~wr1;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 1ns after posedge, outputs sampled at negedge.
// Memory model returns addr ^ 0x5A so rdata pass-through is visible.
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd0, wr0, rd1, wr1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       grant0, grant1, mem_re, mem_we;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_addr ^ 8'h5A;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd0       (rd0),
        .wr0       (wr0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .rd1       (rd1),
        .wr1       (wr1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .grant0    (grant0),
        .grant1    (grant1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to the next cycle's drive point.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
        addr0 = 0; wdata0 = 0; addr1 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        clear_reqs();
        reset = 1;
        next_cyc();
        next_cyc();
        reset = 0;
    endtask

    logic [1:0] burst_pat [9] = '{2'b01, 2'b01, 2'b01, 2'b01,
                                  2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    initial begin
        clear_reqs();
        reset = 1;
        next_cyc();
        next_cyc();
        sample();
        chk("rst_grants", {30'd0, grant1, grant0}, 32'd0);
        chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);

        // Single reader: one idle cycle, then granted and held with saturated counter.
        next_cyc();
        reset = 0;
        rd0 = 1; addr0 = 8'h10;
        sample();
        chk("t1_idle_g0", {31'd0, grant0}, 32'd0);
        next_cyc();
        sample();
        chk("t1_g0", {31'd0, grant0}, 32'd1);
        chk("t1_re", {31'd0, mem_re}, 32'd1);
        chk("t1_addr", {24'd0, mem_addr}, 32'h10);
        chk("t1_rdata", {24'd0, rdata}, 32'h4A);
        for (int i = 0; i < 6; i++) begin
            next_cyc();
            sample();
            chk($sformatf("t1_hold%0d", i), {30'd0, grant1, grant0}, 32'd1);
        end

        // Both request from IDLE: 4 x core0, 4 x core1, then core0.
        do_reset();
        rd0 = 1; addr0 = 8'h01;
        rd1 = 1; addr1 = 8'h02;
        sample();
        chk("t2_idle", {30'd0, grant1, grant0}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            next_cyc();
            sample();
            chk($sformatf("t2_grant%0d", i), {30'd0, grant1, grant0}, {30'd0, burst_pat[i]});
            chk($sformatf("t2_addr%0d", i), {24'd0, mem_addr},
                (burst_pat[i] == 2'b01) ? 32'h01 : 32'h02);
        end

        // Core 0 owner drops its request; core 1 takes over next cycle.
        next_cyc();
        rd0 = 0;
        sample();
        chk("t3_gap", {30'd0, grant1, grant0}, 32'd0);
        next_cyc();
        sample();
        chk("t3_g1", {30'd0, grant1, grant0}, 32'd2);

        // Core 1 write.
        do_reset();
        wr1 = 1; addr1 = 8'h20; wdata1 = 8'hA5;
        sample();
        chk("t4_idle_we", {31'd0, mem_we}, 32'd0);
        chk("t4_idle_bus", {16'd0, mem_addr, mem_wdata}, 32'd0);
        next_cyc();
        sample();
        chk("t4_g1", {30'd0, grant1, grant0}, 32'd2);
        chk("t4_we_re", {30'd0, mem_we, mem_re}, 32'd2);
        chk("t4_bus", {16'd0, mem_addr, mem_wdata}, 32'h20A5);
        next_cyc();
        wr1 = 0;
        sample();
        chk("t4_off_we", {31'd0, mem_we}, 32'd0);
        chk("t4_off_bus", {16'd0, mem_addr, mem_wdata}, 32'd0);

        // Read and write together: write wins.
        do_reset();
        rd0 = 1; wr0 = 1; addr0 = 8'h33; wdata0 = 8'h77;
        next_cyc();
        sample();
        chk("t5_g0", {31'd0, grant0}, 32'd1);
        chk("t5_we_re", {30'd0, mem_we, mem_re}, 32'd2);
        chk("t5_wdata", {24'd0, mem_wdata}, 32'h77);

        // Reset during the third grant of a core 0 burst.
        do_reset();
        rd0 = 1; rd1 = 1; addr0 = 8'h05; addr1 = 8'h06;
        next_cyc();
        next_cyc();
        next_cyc();
        reset = 1;
        sample();
        chk("t6_pre_edge_g0", {30'd0, grant1, grant0}, 32'd1);
        next_cyc();
        sample();
        chk("t6_after_rst", {30'd0, grant1, grant0}, 32'd0);
        next_cyc();
        reset = 0;
        sample();
        chk("t6_idle", {30'd0, grant1, grant0}, 32'd0);
        next_cyc();
        sample();
        chk("t6_first_g0", {30'd0, grant1, grant0}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Never both grants high.
    always @(negedge clk) begin
        if (grant0 && grant1) begin
            chk("both_grants", {30'd0, grant1, grant0}, 32'd0);
        end
    end

endmodule
